// File: rtl/fetch_decode_exec_pkg.sv
// Shared definitions for the fetch/decode/execute slice: widths, RV32I
// opcode and funct3 encodings, the reset NOP, and the ALU operation set.
package fetch_decode_exec_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    // Major opcodes handled by this block
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    // funct3 encodings shared by OP and OP-IMM
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    // The only two funct7 values an OP instruction may carry
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // addi x0,x0,0
    localparam logic [31:0] NOP = 32'h00000013;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_OR,
        ALU_AND,
        ALU_PASS_B,
        ALU_ZERO
    } alu_op_e;

    // Only ADD/SUB and SRL/SRA have an alternate (funct7[5]=1) form
    function automatic logic alt_allowed(input logic [2:0] funct3);
        return (funct3 == F3_ADD_SUB) || (funct3 == F3_SRL_SRA);
    endfunction

    // Map funct3 plus the alternate-form bit to an ALU operation
    function automatic alu_op_e funct3_to_alu(input logic [2:0] funct3,
                                              input logic       alt);
        alu_op_e op;
        case (funct3)
            F3_ADD_SUB: op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:     op = ALU_SLL;
            F3_SLT:     op = ALU_SLT;
            F3_SLTU:    op = ALU_SLTU;
            F3_XOR:     op = ALU_XOR;
            F3_SRL_SRA: op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:      op = ALU_OR;
            default:    op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/fetch_decode_exec_alu.sv
// Integer ALU for the execute stage. Purely combinational; all arithmetic
// wraps at WIDTH bits and shifts use the low five bits of b.
module alu #(
    parameter int WIDTH = fetch_decode_exec_pkg::XLEN
) (
    input  logic [WIDTH-1:0]              a,
    input  logic [WIDTH-1:0]              b,
    input  fetch_decode_exec_pkg::alu_op_e op,
    output logic [WIDTH-1:0]              result
);

    import fetch_decode_exec_pkg::*;

    logic [4:0] shamt;
    logic       lt_signed;
    logic       lt_unsigned;

    assign shamt       = b[4:0];
    assign lt_signed   = $signed(a) < $signed(b);
    assign lt_unsigned = a < b;

    // Select the result of the requested operation; unknown ops give zero
    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:    result = a + b;
            ALU_SUB:    result = a - b;
            ALU_SLL:    result = a << shamt;
            ALU_SRL:    result = a >> shamt;
            ALU_SRA:    result = $signed(a) >>> shamt;
            ALU_SLT:    result[0] = lt_signed;
            ALU_SLTU:   result[0] = lt_unsigned;
            ALU_XOR:    result = a ^ b;
            ALU_OR:     result = a | b;
            ALU_AND:    result = a & b;
            ALU_PASS_B: result = b;
            default:    result = '0;
        endcase
    end

endmodule

// File: rtl/fetch_decode_exec.sv
// Single-cycle fetch/decode/execute slice for a subset of RV32I (OP, OP-IMM,
// LUI). The fetched word is registered once; decode and execute are
// combinational from that register and the register-file read data.
module fetch_decode_exec #(
    parameter int              XLEN     = fetch_decode_exec_pkg::XLEN,
    parameter logic [XLEN-1:0] NOP_INST = fetch_decode_exec_pkg::NOP
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [XLEN-1:0]                           pc,
    output logic [XLEN-1:0]                           rom_addr,
    input  logic [XLEN-1:0]                           rom_data,
    output logic [XLEN-1:0]                           inst,
    output logic [fetch_decode_exec_pkg::REG_ADDR_W-1:0] regs_addr1,
    output logic [fetch_decode_exec_pkg::REG_ADDR_W-1:0] regs_addr2,
    output logic [fetch_decode_exec_pkg::REG_ADDR_W-1:0] regs_write_addr,
    output logic                                      regs_write_en,
    input  logic [XLEN-1:0]                           reg_in1,
    input  logic [XLEN-1:0]                           reg_in2,
    output logic [XLEN-1:0]                           out
);

    import fetch_decode_exec_pkg::*;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_u;
    logic            dec_valid;
    alu_op_e         alu_op;
    logic [XLEN-1:0] operand_b;
    logic [XLEN-1:0] alu_result;

    // The memory sees the requested address directly; word indexing is
    // the memory's concern
    assign rom_addr = pc;

    // Fetch register: reset wins over capture and leaves a harmless NOP
    always_ff @(posedge clk) begin
        if (!rst) begin
            inst <= NOP_INST;
        end else begin
            inst <= rom_data;
        end
    end

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];

    // Register indices are exposed for every word so the register file can
    // start its read before the opcode is known
    assign regs_addr1      = inst[19:15];
    assign regs_addr2      = inst[24:20];
    assign regs_write_addr = inst[11:7];

    assign imm_i = {{(XLEN-12){inst[31]}}, inst[31:20]};
    assign imm_u = XLEN'({inst[31:12], 12'b0});

    // Decode opcode/funct fields into an ALU operation and b operand;
    // anything not recognised becomes ALU_ZERO with no write
    always_comb begin
        dec_valid = 1'b0;
        alu_op    = ALU_ZERO;
        operand_b = reg_in2;
        case (opcode)
            OPC_OP: begin
                if ((funct7 == F7_BASE) ||
                    ((funct7 == F7_ALT) && alt_allowed(funct3))) begin
                    dec_valid = 1'b1;
                    alu_op    = funct3_to_alu(funct3, funct7[5]);
                end
            end
            OPC_OP_IMM: begin
                dec_valid = 1'b1;
                operand_b = imm_i;
                // inst[30] is an immediate bit except on right shifts,
                // where it picks arithmetic over logical
                alu_op    = funct3_to_alu(funct3,
                                          (funct3 == F3_SRL_SRA) && inst[30]);
            end
            OPC_LUI: begin
                dec_valid = 1'b1;
                operand_b = imm_u;
                alu_op    = ALU_PASS_B;
            end
            default: begin
                dec_valid = 1'b0;
            end
        endcase
    end

    alu #(
        .WIDTH (XLEN)
    ) u_alu (
        .a      (reg_in1),
        .b      (operand_b),
        .op     (alu_op),
        .result (alu_result)
    );

    assign out           = alu_result;
    assign regs_write_en = dec_valid && (regs_write_addr != '0);

endmodule

// File: tb/tb_fetch_decode_exec.sv
// Self-checking bench for fetch_decode_exec: directed cases plus randomized
// instructions checked against a behavioural RV32I subset model.
module tb_fetch_decode_exec;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic [31:0] inst;
    logic [4:0]  regs_addr1;
    logic [4:0]  regs_addr2;
    logic [4:0]  regs_write_addr;
    logic        regs_write_en;
    logic [31:0] reg_in1;
    logic [31:0] reg_in2;
    logic [31:0] out;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_decode_exec #(
        .XLEN     (32),
        .NOP_INST (32'h00000013)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .pc              (pc),
        .rom_addr        (rom_addr),
        .rom_data        (rom_data),
        .inst            (inst),
        .regs_addr1      (regs_addr1),
        .regs_addr2      (regs_addr2),
        .regs_write_addr (regs_write_addr),
        .regs_write_en   (regs_write_en),
        .reg_in1         (reg_in1),
        .reg_in2         (reg_in2),
        .out             (out)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the run ever stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Reference: result of one supported operation, plain arithmetic
    function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic alt,
                                           input logic [31:0] x, input logic [31:0] y);
        logic [31:0] ones;
        int unsigned sh;
        ones = 32'hFFFFFFFF;
        sh   = y % 32;
        case (f3)
            3'd0: return alt ? x - y : x + y;
            3'd1: return x << sh;
            3'd2: return (int'(x) < int'(y)) ? 32'd1 : 32'd0;
            3'd3: return (x < y) ? 32'd1 : 32'd0;
            3'd4: return x ^ y;
            3'd5: return alt ? ((x >> sh) | (x[31] ? ~(ones >> sh) : 32'd0)) : (x >> sh);
            3'd6: return x | y;
            default: return x & y;
        endcase
    endfunction

    // Reference: write enable and result for a whole instruction word
    function automatic void ref_model(input logic [31:0] w, input logic [31:0] x,
                                      input logic [31:0] y, output logic en,
                                      output logic [31:0] res);
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic        ok;
        opc = w[6:0];
        f3  = w[14:12];
        f7  = w[31:25];
        imm = {{20{w[31]}}, w[31:20]};
        ok  = 1'b0;
        res = 32'd0;
        if (opc == 7'b0110011) begin
            if (f7 == 7'd0) begin
                ok = 1'b1; res = ref_op(f3, 1'b0, x, y);
            end else if (f7 == 7'b0100000 && (f3 == 3'd0 || f3 == 3'd5)) begin
                ok = 1'b1; res = ref_op(f3, 1'b1, x, y);
            end
        end else if (opc == 7'b0010011) begin
            ok  = 1'b1;
            res = ref_op(f3, (f3 == 3'd5) && w[30], x, imm);
        end else if (opc == 7'b0110111) begin
            ok  = 1'b1;
            res = {w[31:12], 12'd0};
        end
        en = ok && (w[11:7] != 5'd0);
    endfunction

    // Random instruction word biased toward interesting encodings
    function automatic logic [31:0] rand_inst();
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] w;
        f3  = 3'($urandom_range(0, 7));
        rd  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        rs1 = 5'($urandom);
        rs2 = 5'($urandom);
        f7  = ($urandom_range(0, 1) == 1) ? 7'b0100000 : 7'd0;
        case ($urandom_range(0, 5))
            0: w = {((f3 == 3'd0 || f3 == 3'd5) ? f7 : 7'd0), rs2, rs1, f3, rd, 7'b0110011};
            1: w = {7'($urandom), rs2, rs1, f3, rd, 7'b0110011};
            2: w = {7'b0100000, rs2, rs1, f3, rd, 7'b0110011};
            3: begin
                if (f3 == 3'd1) w = {7'd0, rs2, rs1, f3, rd, 7'b0010011};
                else if (f3 == 3'd5) w = {f7, rs2, rs1, f3, rd, 7'b0010011};
                else w = {12'($urandom), rs1, f3, rd, 7'b0010011};
            end
            4: w = {20'($urandom), rd, 7'b0110111};
            default: w = $urandom;
        endcase
        return w;
    endfunction

    // Put a word on the memory bus and let one rising edge capture it
    task automatic applyStimulus(input logic [31:0] word);
        rom_data = word;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; rom_data = 32'hFFFFFFFF; reg_in1 = 32'd0; reg_in2 = 32'd0; pc = 32'd0;
        @(posedge clk);
        #1;
        n_checks++;
        if (inst !== 32'h00000013) begin
            n_fail++; $display("[TB] FAIL reset_inst got %h want %h", inst, 32'h00000013);
        end
        n_checks++;
        if (regs_write_en !== 1'b0) begin
            n_fail++; $display("[TB] FAIL reset_wen got %b want 0", regs_write_en);
        end
        n_checks++;
        if (out !== 32'd0) begin
            n_fail++; $display("[TB] FAIL reset_out got %h want 0", out);
        end
    endtask

    task automatic test_add();
        rst = 1'b1;
        applyStimulus(32'h002081B3);
        reg_in1 = 32'd5; reg_in2 = 32'd7;
        #1;
        n_checks++;
        if (inst !== 32'h002081B3) begin
            n_fail++; $display("[TB] FAIL add_inst got %h want %h", inst, 32'h002081B3);
        end
        n_checks++;
        if ({regs_addr1, regs_addr2, regs_write_addr} !== {5'd1, 5'd2, 5'd3}) begin
            n_fail++; $display("[TB] FAIL add_fields got %0d/%0d/%0d want 1/2/3",
                               regs_addr1, regs_addr2, regs_write_addr);
        end
        n_checks++;
        if (regs_write_en !== 1'b1) begin
            n_fail++; $display("[TB] FAIL add_wen got %b want 1", regs_write_en);
        end
        n_checks++;
        if (out !== 32'd12) begin
            n_fail++; $display("[TB] FAIL add_out got %h want %h", out, 32'd12);
        end
    endtask

    task automatic test_directed();
        logic [31:0] words [7];
        logic [31:0] ain   [7];
        logic [31:0] bin   [7];
        logic [31:0] want  [7];
        logic        wen   [7];
        words = '{32'h402081B3, 32'h4020D1B3, 32'h0020D1B3, 32'hFFF08293,
                  32'h00000073, 32'h0020A1B3, 32'h0020B1B3};
        ain   = '{32'd5, 32'h80000000, 32'h80000000, 32'd0, 32'd9, 32'h80000000, 32'h80000000};
        bin   = '{32'd7, 32'd4, 32'd4, 32'd3, 32'd9, 32'd1, 32'd1};
        want  = '{32'hFFFFFFFE, 32'hF8000000, 32'h08000000, 32'hFFFFFFFF,
                  32'd0, 32'd1, 32'd0};
        wen   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 7; i++) begin
            applyStimulus(words[i]);
            reg_in1 = ain[i]; reg_in2 = bin[i];
            #1;
            n_checks++;
            if (out !== want[i]) begin
                n_fail++; $display("[TB] FAIL directed_out[%0d] inst %h got %h want %h",
                                   i, words[i], out, want[i]);
            end
            n_checks++;
            if (regs_write_en !== wen[i]) begin
                n_fail++; $display("[TB] FAIL directed_wen[%0d] inst %h got %b want %b",
                                   i, words[i], regs_write_en, wen[i]);
            end
        end
    endtask

    task automatic test_pc_sweep();
        logic [31:0] data [3];
        data = '{32'hCAFE0013, 32'h12345678, 32'hA5A5A5A5};
        for (int i = 0; i < 3; i++) begin
            pc = 32'(i * 4);
            rom_data = data[i];
            #1;
            n_checks++;
            if (rom_addr !== 32'(i * 4)) begin
                n_fail++; $display("[TB] FAIL sweep_addr[%0d] got %h want %h", i, rom_addr, 32'(i * 4));
            end
            n_checks++;
            if (i > 0 && inst !== data[i-1]) begin
                n_fail++; $display("[TB] FAIL sweep_hold[%0d] got %h want %h", i, inst, data[i-1]);
            end
            @(posedge clk);
            #1;
            n_checks++;
            if (inst !== data[i]) begin
                n_fail++; $display("[TB] FAIL sweep_inst[%0d] got %h want %h", i, inst, data[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] w;
        logic [31:0] want;
        logic        wen;
        for (int i = 0; i < 300; i++) begin
            w = rand_inst();
            applyStimulus(w);
            reg_in1 = ($urandom_range(0, 3) == 0) ? 32'h80000000 ^ 32'($urandom_range(0, 3)) : $urandom;
            reg_in2 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            #1;
            ref_model(w, reg_in1, reg_in2, wen, want);
            n_checks++;
            if (inst !== w) begin
                n_fail++; $display("[TB] FAIL rand_inst[%0d] got %h want %h", i, inst, w);
            end
            n_checks++;
            if ({regs_addr1, regs_addr2, regs_write_addr} !== {w[19:15], w[24:20], w[11:7]}) begin
                n_fail++; $display("[TB] FAIL rand_fields[%0d] inst %h got %0d/%0d/%0d", i, w,
                                   regs_addr1, regs_addr2, regs_write_addr);
            end
            n_checks++;
            if (regs_write_en !== wen) begin
                n_fail++; $display("[TB] FAIL rand_wen[%0d] inst %h got %b want %b", i, w, regs_write_en, wen);
            end
            n_checks++;
            if (out !== want) begin
                n_fail++; $display("[TB] FAIL rand_out[%0d] inst %h a %h b %h got %h want %h",
                                   i, w, reg_in1, reg_in2, out, want);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] prev;
        logic [31:0] w;
        prev = inst;
        // Reset arriving mid-stream must beat the word on the bus
        rst = 1'b0;
        reg_in1 = 32'd0; reg_in2 = 32'd0;
        applyStimulus(32'h002081B3);
        n_checks++;
        if (inst !== 32'h00000013) begin
            n_fail++; $display("[TB] FAIL b2b_reset_prio got %h want %h (prev %h)", inst, 32'h00000013, prev);
        end
        n_checks++;
        if (out !== 32'd0 || regs_write_en !== 1'b0) begin
            n_fail++; $display("[TB] FAIL b2b_reset_out got %h/%b want 0/0", out, regs_write_en);
        end
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            w = $urandom;
            applyStimulus(w);
            n_checks++;
            if (inst !== w) begin
                n_fail++; $display("[TB] FAIL b2b_inst[%0d] got %h want %h", i, inst, w);
            end
        end
    endtask

    initial begin
        rst = 1'b0; pc = 32'd0; rom_data = 32'd0; reg_in1 = 32'd0; reg_in2 = 32'd0;
        #2;
        test_reset();
        test_add();
        test_directed();
        test_pc_sweep();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_decode_exec.md
FETCH_DECODE_EXEC -- requirements
Module: fetch_decode_exec

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data/address width.
REQ-002 SHALL have parameter NOP_INST, default 32'h00000013, meaning instruction loaded on reset (addi x0,x0,0).
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 pc  input  XLEN  byte address of the instruction to fetch.
REQ-006 rom_addr  output  XLEN  instruction memory address.
REQ-007 rom_data  input  XLEN  instruction word returned by memory for rom_addr.
REQ-008 inst  output  XLEN  currently held instruction, from the fetch register.
REQ-009 regs_addr1  output  5  rs1 index.
REQ-010 regs_addr2  output  5  rs2 index.
REQ-011 regs_write_addr  output  5  rd index.
REQ-012 regs_write_en  output  1  register-file write enable for the current inst.
REQ-013 reg_in1  input  XLEN  register-file read data for regs_addr1.
REQ-014 reg_in2  input  XLEN  register-file read data for regs_addr2.
REQ-015 out  output  XLEN  execute result, the write data to the register file.

Function
REQ-016 rom_addr SHALL equal pc combinationally; memory word indexing is external to this block.
REQ-017 Fetch SHALL register rom_data into inst on every rising clk when rst=1, giving 1-cycle fetch latency.
REQ-018 Decode and execute SHALL be purely combinational from inst, reg_in1 and reg_in2, with no added latency.
REQ-019 Field extraction from inst: regs_addr1=inst[19:15], regs_addr2=inst[24:20], regs_write_addr=inst[11:7]; these are always driven, regardless of opcode.
REQ-020 Supported opcodes: OP (0110011), OP-IMM (0010011), LUI (0110111).
REQ-021 OP, selected by funct3/funct7[5], with operands a=reg_in1 and b=reg_in2:
- ADD, SUB
- SLL, SRL, SRA: shift amount is b[4:0]
- SLT (signed compare), SLTU (unsigned compare): result is 1 or 0, zero-extended
- XOR, OR, AND
REQ-022 OP-IMM SHALL use b = sign-extended inst[31:20] and implement ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
- Shift amount is inst[24:20]; inst[30] selects SRAI.
REQ-023 LUI SHALL produce out = {inst[31:12], 12'b0}.
REQ-024 regs_write_en SHALL be 1 only for a supported opcode with rd != 0.
REQ-025 An unsupported opcode or an undefined funct7 (OP with funct7 other than 0000000/0100000, or SUB/SRA variants of non-add/shift) SHALL drive regs_write_en=0 and out=0.
REQ-026 Arithmetic SHALL wrap modulo 2^XLEN, with no overflow flag.
REQ-027 SRA SHALL replicate bit XLEN-1.

Reset
REQ-028 On a rising clk with rst=0, inst SHALL load NOP_INST, which gives regs_write_en=0 and out=0 at the outputs.
REQ-029 Reset SHALL take priority over the fetch capture in the same cycle.
REQ-030 When rst returns to 1, the first fetched word SHALL appear on inst one clk later.

Structure
REQ-031 A shared package SHALL hold:
- XLEN and REG_ADDR width (5)
- opcode constants OP/OP_IMM/LUI
- funct3 encodings and the NOP constant
REQ-032 The ALU SHALL be one sub-module, named alu: inputs a, b, op select; output result.
REQ-033 Fetch register and decoder SHALL stay in the top module.

Verification
REQ-034 Hold rst=0 for one clk, rom_data=32'hFFFFFFFF -> inst=32'h00000013, regs_write_en=0, out=0.
REQ-035 rst=1, rom_data=32'h002081B3 (add x3,x1,x2), next clk, reg_in1=5, reg_in2=7 -> regs_addr1=1, regs_addr2=2, regs_write_addr=3, regs_write_en=1, out=12.
REQ-036 inst=32'h402081B3 (sub), reg_in1=5, reg_in2=7 -> out=32'hFFFFFFFE.
REQ-037 inst=32'h4020D1B3 (sra), reg_in1=32'h80000000, reg_in2=4 -> out=32'hF8000000; same operands with srl (32'h0020D1B3) -> out=32'h08000000.
REQ-038 inst=32'hFFF08293 (addi x5,x1,-1), reg_in1=0 -> out=32'hFFFFFFFF, regs_write_en=1; inst=32'h00000073 -> regs_write_en=0, out=0.
REQ-039 Sweep pc=0,4,8 with distinct rom_data values -> rom_addr tracks pc the same cycle and each value appears on inst exactly one clk later.
